mmio_uart_bridge: RTL
=====================

// Module: mmio_uart_bridge
// PURPOSE
//  Data-side bus stage directly downstream of the multicycle core: decodes DataAdr, routes accesses
//  to the unified RAM or to a memory-mapped UART transmitter, and muxes ReadData back to the core.
//  UART has a TX FIFO, a baud divider and a frame state machine. Core has no stall, so all MMIO
//  reads return registered state combinationally (same cycle, like the RAM read path).
// PARAMETERS
//  WIDTH         32     data/address width
//  FIFO_DEPTH    4      TX FIFO entries; power of 2, >=2
//  BAUD_DIV_RST  16     reset value of BAUDDIV (clk cycles per UART bit)
//  MMIO_NIBBLE   4'hF   DataAdr[31:28] value selecting MMIO space; anything else -> RAM
// PORTS
//  clk          in   1      core clock; all state updates on posedge
//  reset        in   1      asynchronous, active-high
//  MemWrite     in   1      write strobe from core; one write per posedge it is high
//  DataAdr      in   WIDTH  byte address from core
//  WriteData    in   WIDTH  store data from core
//  ReadData     out  WIDTH  read data to core (combinational mux)
//  RamReadData  in   WIDTH  RAM read data (RAM reads combinationally)
//  RamWrite     out  1      RAM write enable = MemWrite & ~mmio_sel
//  UartTx       out  1      serial output, idle high
// BEHAVIOUR
//  Decode: mmio_sel = (DataAdr[31:28]==MMIO_NIBBLE); offset = DataAdr[3:2]; DataAdr[1:0] ignored.
//  ReadData = mmio_sel ? mmio_rd : RamReadData. Unmapped MMIO offsets read 0.
//  Register map (MMIO):
//   0x0 TXDATA  W: push WriteData[7:0] into FIFO. R: 0.
//   0x4 STATUS  R: {28'b0, ovf, busy, empty, full}. W: writing 1 to bit3 clears ovf; other bits RO.
//   0x8 BAUDDIV R/W: [15:0] cycles per bit; write of 0 stored as 1; upper bits read 0.
//   0xC CYCLE   R: free-running counter (see CONFIGURATION). Writes ignored.
//  Reset values: ReadData follows mux; RamWrite follows MemWrite; UartTx=1; FIFO empty (count 0);
//   ovf=0; BAUDDIV=BAUD_DIV_RST; state=IDLE; bit counter 0; baud counter 0; CYCLE=0.
//  FIFO: count in 0..FIFO_DEPTH, read/write pointers wrap modulo FIFO_DEPTH.
//   full=(count==FIFO_DEPTH); empty=(count==0).
//   Push when full is dropped and sets ovf (sticky), judged on pre-edge count even if a pop
//   occurs the same edge. Simultaneous push+pop when not full/not empty: count unchanged.
//  TX FSM (busy = state!=IDLE):
//   IDLE : if !empty -> pop, UartTx<=0, load baud cnt, -> START (TX goes low 1 cycle after push).
//   START: hold 0 for BAUDDIV cycles -> DATA, drive bit0.
//   DATA : 8 bits LSB first, each BAUDDIV cycles -> STOP.
//   STOP : UartTx=1 for BAUDDIV cycles -> IDLE; if FIFO non-empty, frame restarts next cycle.
//   Baud counter reloads BAUDDIV-1 at each bit start; BAUDDIV write mid-frame applies at next bit.
//   Frame = 10*BAUDDIV cycles of start/data/stop.
//  Reset mid-frame: UartTx returns to 1 immediately (async), FIFO contents discarded.
//  Width: CYCLE wraps 2^WIDTH-1 -> 0 with no flag.
// CONFIGURATION
//  `MMIO_CYCLE_COUNTER_EN defined: CYCLE is a WIDTH-bit counter, +1 every clk, reset to 0.
//  Not defined: no counter flops; offset 0xC reads 0.
// TESTING
//  1 RAM path: MemWrite=1, DataAdr=0x0000_0040 -> RamWrite=1; read 0x40 -> ReadData=RamReadData.
//  2 MMIO write 0xF000_0000 data 0x55 (BAUDDIV=4) -> RamWrite=0; UartTx low 1 cycle later;
//    bits 1,0,1,0,1,0,1,0 every 4 cycles; stop high; idle after 40 cycles; STATUS=0x2 at end.
//  3 Five back-to-back pushes at BAUDDIV=16, DEPTH=4: first pops immediately, 4 queued -> full=1,
//    no ovf; sixth push -> ovf=1, byte dropped; write 0x8 to STATUS -> ovf=0.
//  4 BAUDDIV write 0 -> reads back 1; frame of 0xFF lasts 10 cycles.
//  5 Assert reset mid-DATA of 0x00 -> UartTx=1 at once, STATUS=0x2, BAUDDIV=BAUD_DIV_RST.
//  6 With MMIO_CYCLE_COUNTER_EN: two reads of 0xF000_000C 10 cycles apart differ by 10;
//    without: both read 0.

Source files
------------

// File: rtl/mmio_uart_bridge.sv
// Data-side bus stage: RAM/MMIO decode with a memory-mapped UART transmitter.
// Optional CYCLE counter at offset 0xC is enabled by `MMIO_CYCLE_COUNTER_EN.
module mmio_uart_bridge #(
  parameter int         WIDTH        = 32,
  parameter int         FIFO_DEPTH   = 4,
  parameter int         BAUD_DIV_RST = 16,
  parameter logic [3:0] MMIO_NIBBLE  = 4'hF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemWrite,
  input  logic [WIDTH-1:0] DataAdr,
  input  logic [WIDTH-1:0] WriteData,
  output logic [WIDTH-1:0] ReadData,
  input  logic [WIDTH-1:0] RamReadData,
  output logic             RamWrite,
  output logic             UartTx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];
  localparam logic [15:0] BAUD_RST = BAUD_DIV_RST[15:0];

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic          mmio_sel;
  logic [1:0]    off;
  logic          wr_tx, wr_st, wr_bd;
  logic          full, empty, busy;
  logic          push, pop;
  logic          unused_bits;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   baud_q, baud_d;

  state_t        state_q;
  logic          tx_q;
  logic [7:0]    shift_q;
  logic [2:0]    bit_q;
  logic [15:0]   bcnt_q;

  logic [WIDTH-1:0] mmio_rd, cycle_rd;

  assign mmio_sel = DataAdr[WIDTH-1 -: 4] == MMIO_NIBBLE;
  assign off      = DataAdr[3:2];
  assign wr_tx    = MemWrite & mmio_sel & (off == 2'd0);
  assign wr_st    = MemWrite & mmio_sel & (off == 2'd1);
  assign wr_bd    = MemWrite & mmio_sel & (off == 2'd2);

  assign full  = count_q == FULL_CNT;
  assign empty = count_q == '0;
  assign busy  = state_q != IDLE;
  assign pop   = (state_q == IDLE) & ~empty;
  assign push  = wr_tx & ~full;

  assign RamWrite = MemWrite & ~mmio_sel;
  assign ReadData = mmio_sel ? mmio_rd : RamReadData;
  assign UartTx   = tx_q;

  assign unused_bits = ^{DataAdr[WIDTH-5:4], DataAdr[1:0],
                         WriteData[WIDTH-1:16]};

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Overflow judged on pre-edge fullness, even with a pop this edge
    ovf_d = ovf_q;
    if (wr_tx & full)
      ovf_d = 1'b1;
    else if (wr_st & WriteData[3])
      ovf_d = 1'b0;
    baud_d = baud_q;
    if (wr_bd)
      baud_d = (WriteData[15:0] == 16'd0) ? 16'd1 : WriteData[15:0];
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wp_q] <= WriteData[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      baud_q  <= BAUD_RST;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop)  rp_q <= rp_q + 1'b1;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      baud_q  <= baud_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      shift_q <= '0;
      bit_q   <= '0;
      bcnt_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (!empty) begin
          shift_q <= mem_q[rp_q];
          tx_q    <= 1'b0;
          bcnt_q  <= baud_q - 16'd1;
          state_q <= START;
        end
        START: if (bcnt_q == 16'd0) begin
          tx_q    <= shift_q[0];
          bit_q   <= '0;
          bcnt_q  <= baud_q - 16'd1;
          state_q <= DATA;
        end else begin
          bcnt_q <= bcnt_q - 16'd1;
        end
        DATA: if (bcnt_q == 16'd0) begin
          bcnt_q <= baud_q - 16'd1;
          if (bit_q == 3'd7) begin
            tx_q    <= 1'b1;
            state_q <= STOP;
          end else begin
            tx_q    <= shift_q[1];
            shift_q <= {1'b0, shift_q[7:1]};
            bit_q   <= bit_q + 1'b1;
          end
        end else begin
          bcnt_q <= bcnt_q - 16'd1;
        end
        STOP: if (bcnt_q == 16'd0) begin
          state_q <= IDLE;
        end else begin
          bcnt_q <= bcnt_q - 16'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MMIO_CYCLE_COUNTER_EN
  logic [WIDTH-1:0] cycle_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cycle_q <= '0;
    else       cycle_q <= cycle_q + 1'b1;
  end
  assign cycle_rd = cycle_q;
`else
  assign cycle_rd = '0;
`endif

  always_comb begin
    mmio_rd = '0;
    unique case (off)
      2'd0: mmio_rd = '0;
      2'd1: mmio_rd[3:0] = {ovf_q, busy, empty, full};
      2'd2: mmio_rd[15:0] = baud_q;
      2'd3: mmio_rd = cycle_rd;
      default: mmio_rd = '0;
    endcase
  end

endmodule
